// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: registered single-cycle RV base ops plus iterative
// shift-add multiply and restoring divide for the M extension, valid/ready on both sides.
`timescale 1ns/1ps
module alu_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ctr,
  input  logic            mext,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   mcand_q, mcand_d, result_q, result_d;
  logic [2:0]        fn_q, fn_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]    cnt_q, cnt_d;

  // {a_neg, b_neg}: which operands are treated as negative for this M funct3.
  function automatic logic [1:0] neg_flags(input logic [2:0] fn, input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    logic a_sgn, b_sgn;
    if (fn[2]) begin
      a_sgn = ~fn[0];
      b_sgn = ~fn[0];
    end else begin
      a_sgn = (fn == 3'b001) || (fn == 3'b010);
      b_sgn = (fn == 3'b001);
    end
    return {a_sgn & a[XLEN-1], b_sgn & b[XLEN-1]};
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;

  assign in_ready  = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign shamt     = op_b[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (ctr)
      4'b0000: base_res = op_a + op_b;
      4'b1000: base_res = op_a - op_b;
      4'b0001: base_res = op_a << shamt;
      4'b0010: base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'b0011: base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'b0100: base_res = op_a ^ op_b;
      4'b0101: base_res = op_a >> shamt;
      4'b1101: base_res = $unsigned($signed(op_a) >>> shamt);
      4'b0110: base_res = op_a | op_b;
      4'b0111: base_res = op_a & op_b;
      default: base_res = '0;
    endcase
  end

  // Magnitudes are taken from the request itself so iteration starts on the first CALC edge.
  logic [1:0]      in_neg, q_neg;
  logic [XLEN-1:0] in_mag_a, in_mag_b;
  assign in_neg   = neg_flags(ctr[2:0], op_a, op_b);
  assign in_mag_a = cond_neg(in_neg[1], op_a);
  assign in_mag_b = cond_neg(in_neg[0], op_b);
  assign q_neg    = neg_flags(fn_q, a_q, b_q);

  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN-1:0]   div_rem, quot, rem;
  logic              div_ge;
  logic [2*XLEN-1:0] step, prod_s;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge  = (div_sh >= {1'b0, mcand_q});
    div_rem = div_sh[XLEN-1:0] - mcand_q;
    if (fn_q[2])
      step = div_ge ? {div_rem, acc_q[XLEN-2:0], 1'b1} : {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else
      step = {mul_sum, acc_q[XLEN-1:1]};
    prod_s = (q_neg[1] ^ q_neg[0]) ? -step : step;
    quot   = step[XLEN-1:0];
    rem    = step[2*XLEN-1:XLEN];
    case (fn_q)
      3'b000:         final_res = step[XLEN-1:0];
      3'b100, 3'b101: final_res = (b_q == '0) ? '1 : cond_neg(q_neg[1] ^ q_neg[0], quot);
      3'b110, 3'b111: final_res = (b_q == '0) ? a_q : cond_neg(q_neg[1], rem);
      default:        final_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  // NOTE: every variable gets its hold value first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    fn_d     = fn_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      a_d  = op_a;
      b_d  = op_b;
      fn_d = ctr[2:0];
      if (mext) begin
        state_d = S_CALC;
        cnt_d   = '0;
        acc_d   = ctr[2] ? {{XLEN{1'b0}}, in_mag_a} : {{XLEN{1'b0}}, in_mag_b};
        mcand_d = ctr[2] ? in_mag_b : in_mag_a;
      end else begin
        state_d  = S_DONE;
        result_d = base_res;
      end
    end else begin
      case (state_q)
        S_DONE: if (out_ready) state_d = S_IDLE;
        S_CALC: begin
          acc_d = step;
          cnt_d = cnt_q + SHW'(1);
          if (cnt_q == LAST) begin
            state_d  = S_DONE;
            result_d = final_res;
          end
        end
        default: ;
      endcase
    end
    // A kill abandons the op; the visible result keeps its previous value.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
      cnt_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      fn_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fn_q     <= fn_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
endmodule
